// File: rtl/seq_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
package seq_pkg;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB
   } state_e;

   typedef enum logic [2:0] {
      CL_R,
      CL_I,
      CL_LOAD,
      CL_STORE,
      CL_BRANCH,
      CL_JAL,
      CL_ILLEGAL
   } iclass_e;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   localparam logic [1:0] PCSEL_PC4   = 2'b00;
   localparam logic [1:0] PCSEL_BR    = 2'b01;
   localparam logic [1:0] PCSEL_JMP   = 2'b10;
   localparam logic [1:0] PCSEL_ENTRY = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   function automatic logic class_alu_src(input iclass_e c);
      return (c == CL_I) || (c == CL_LOAD) || (c == CL_STORE) || (c == CL_JAL);
   endfunction

   function automatic logic [1:0] class_alu_op(input iclass_e c);
      logic [1:0] op;
      op = ALUOP_ADD;
      if (c == CL_R)      op = ALUOP_FUNCT;
      if (c == CL_BRANCH) op = ALUOP_SUB;
      return op;
   endfunction

endpackage

// File: rtl/seq_class_decode.sv
// Combinational opcode-to-instruction-class decoder; zero latency, no handshake.
module seq_class_decode
   import seq_pkg::*;
(
   input  logic [6:0] opcode,
   output iclass_e    iclass
);

   always_comb begin
      iclass = CL_ILLEGAL;
      case (opcode)
         OP_R:      iclass = CL_R;
         OP_I:      iclass = CL_I;
         OP_LOAD:   iclass = CL_LOAD;
         OP_STORE:  iclass = CL_STORE;
         OP_BRANCH: iclass = CL_BRANCH;
         OP_JAL:    iclass = CL_JAL;
         default:   iclass = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RISC-V control FSM: 2..5+ cycles per instruction, stalls in MEM until mem_ready
// (bus-error trap after MAX_WAIT wait cycles). SEQ_PERF_CNT_EN adds cycle/retired counters.
module multicycle_sequencer
   import seq_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   input  logic        int_req,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        reg_we,
   output logic        alu_src,
   output logic [1:0]  alu_op,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        mem2reg,
   output logic        int_ack,
   output logic        trap,
   output logic        done
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] retired_cnt
`endif
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);
   localparam logic [WW-1:0] WAIT_ONE = WW'(1);

   state_e        state_q, state_d;
   iclass_e       class_q, class_d;
   iclass_e       dec_class;
   logic [WW-1:0] wait_q, wait_d;
   logic          fin;

   seq_class_decode u_dec (
      .opcode (opcode),
      .iclass (dec_class)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RESET;
         class_q <= CL_ILLEGAL;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      class_d = class_q;
      wait_d  = wait_q;
      fin     = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      pc_sel  = PCSEL_PC4;
      reg_we  = 1'b0;
      alu_src = 1'b0;
      alu_op  = ALUOP_ADD;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      mem2reg = 1'b0;
      int_ack = 1'b0;
      trap    = 1'b0;
      done    = 1'b0;

      // ALU controls stay stable from EXEC to the end of the instruction.
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
         alu_src = class_alu_src(class_q);
         alu_op  = class_alu_op(class_q);
      end

      case (state_q)
         ST_RESET: begin
            pc_we   = 1'b1;
            pc_sel  = PCSEL_ENTRY;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            ir_we   = 1'b1;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            class_d = dec_class;
            if (dec_class == CL_ILLEGAL) begin
               trap    = 1'b1;
               pc_we   = 1'b1;
               pc_sel  = PCSEL_ENTRY;
               done    = 1'b1;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (class_q)
               CL_BRANCH: begin
                  pc_we  = 1'b1;
                  pc_sel = zero ? PCSEL_BR : PCSEL_PC4;
                  fin    = 1'b1;
               end
               CL_LOAD, CL_STORE: begin
                  wait_d  = '0;
                  state_d = ST_MEM;
               end
               default: state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            // The timeout is decided from the counter alone, so it wins over a late mem_ready.
            if (wait_q == WAIT_LIM) begin
               trap    = 1'b1;
               pc_we   = 1'b1;
               pc_sel  = PCSEL_ENTRY;
               done    = 1'b1;
               state_d = ST_FETCH;
            end else begin
               mem_rd = (class_q == CL_LOAD);
               mem_wr = (class_q == CL_STORE);
               if (mem_ready) begin
                  if (class_q == CL_LOAD) begin
                     state_d = ST_WB;
                  end else begin
                     pc_we  = 1'b1;
                     pc_sel = PCSEL_PC4;
                     fin    = 1'b1;
                  end
               end else begin
                  wait_d = wait_q + WAIT_ONE;
               end
            end
         end
         ST_WB: begin
            reg_we  = 1'b1;
            mem2reg = (class_q == CL_LOAD);
            pc_we   = 1'b1;
            pc_sel  = (class_q == CL_JAL) ? PCSEL_JMP : PCSEL_PC4;
            fin     = 1'b1;
         end
         default: state_d = ST_RESET;
      endcase

      // Interrupts are taken only on a normal (non-trap) instruction boundary.
      if (fin) begin
         done    = 1'b1;
         state_d = ST_FETCH;
         if (int_req) begin
            pc_sel  = PCSEL_ENTRY;
            int_ack = 1'b1;
         end
      end

      if (!rst_n) begin
         ir_we   = 1'b0;
         pc_we   = 1'b0;
         pc_sel  = PCSEL_PC4;
         reg_we  = 1'b0;
         alu_src = 1'b0;
         alu_op  = ALUOP_ADD;
         mem_rd  = 1'b0;
         mem_wr  = 1'b0;
         mem2reg = 1'b0;
         int_ack = 1'b0;
         trap    = 1'b0;
         done    = 1'b0;
      end
   end

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cycle_q, retired_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q   <= '0;
         retired_q <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         if (done && !trap) retired_q <= retired_q + 32'd1;
      end
   end

   assign cycle_cnt   = cycle_q;
   assign retired_cnt = retired_q;
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the single-issue RISC-V datapath (fetch, decode, execute, data memory, writeback and PC stages). It replaces the single-cycle control decode with an FSM: one instruction runs over 3–5+ clock cycles, and the block drives the stage enables and mux selects in each cycle. It also tolerates variable-latency data memory through a ready handshake, traps on illegal opcodes or memory timeout, and services an external interrupt at instruction boundaries by redirecting the PC to the entry point.

## Interface
- MAX_WAIT, 15: data-memory wait cycles allowed before a bus-error trap (≥1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  ins[6:0] from the instruction register; valid from DECODE onward.
- zero  in  1  ALU zero flag; valid in EXEC.
- mem_ready  in  1  data memory completed the access this cycle.
- int_req  in  1  level interrupt request.
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC at end of cycle.
- pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 entry point.
- reg_we  out  1  register-file write.
- alu_src  out  1  1 = immediate operand.
- alu_op  out  2  00 add, 01 sub (branch), 10 funct3-decoded (R-type).
- mem_rd  out  1  data-memory read request.
- mem_wr  out  1  data-memory write request.
- mem2reg  out  1  writeback selects memory data.
- int_ack  out  1  one-cycle pulse when the interrupt is taken.
- trap  out  1  one-cycle pulse on illegal opcode or memory timeout.
- done  out  1  one-cycle pulse in the last cycle of each instruction.

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB.
- Instruction classes, latched from opcode in DECODE:
  - 0x33 R
  - 0x13 I
  - 0x03 LOAD
  - 0x23 STORE
  - 0x63 BRANCH
  - 0x6F JAL
  - anything else ILLEGAL
- RESET: pc_we=1, pc_sel=11. Goes to FETCH.
- FETCH: ir_we=1. Goes to DECODE.
- DECODE: no enables. ILLEGAL goes to FETCH with the trap redirect; all other classes go to EXEC.
- EXEC: alu_src and alu_op per class.
  - BRANCH ends here: pc_we=1, pc_sel = zero ? 01 : 00.
  - LOAD and STORE go to MEM.
  - R, I and JAL go to WB.
- MEM: mem_rd (LOAD) or mem_wr (STORE) held continuously until the cycle mem_ready=1.
  - LOAD: goes to WB.
  - STORE: ends in that cycle with pc_we=1, pc_sel=00.
- WB: reg_we=1; mem2reg=1 for LOAD only.
  - pc_we=1; pc_sel=10 for JAL, 00 otherwise.
- Signals held through the instruction: alu_src (1 for I/LOAD/STORE/JAL) and alu_op are held stable from EXEC through the end of the instruction.
- Final cycle of each instruction (done=1):
  - If int_req=1, pc_sel is forced to 11 and int_ack=1.
  - The instruction's own reg/mem writes still complete; the branch or jump redirect is discarded.
  - Next state is FETCH.
- Memory timeout:
  - The wait counter counts MEM cycles with mem_ready=0.
  - When it reaches MAX_WAIT: trap=1, pc_we=1, pc_sel=11, done=1, no reg_we, mem request dropped, next FETCH.
- Illegal opcode: in the DECODE cycle, trap=1, pc_we=1, pc_sel=11, done=1.
- Precedence in a trap cycle: trap has priority over a simultaneous interrupt. int_ack=0 and the interrupt stays pending.
- mem_ready outside MEM is ignored.

## Timing
- Reset values: state=RESET; wait counter=0; ir_we, pc_we, reg_we, mem_rd, mem_wr, mem2reg, int_ack, trap, done = 0; pc_sel=00; alu_src=0; alu_op=00.
- First rising edge after rst_n deasserts executes RESET.
- Outputs are Moore-style: decoded from state, the latched class and the wait counter. Exceptions: pc_sel uses zero in BRANCH/EXEC and int_req in final cycles; MEM exit uses mem_ready.
- Latency in cycles:
  - BRANCH 3
  - R, I, JAL 4
  - STORE 4+w
  - LOAD 5+w
  - ILLEGAL 2
  - w = cycles with mem_ready=0 before ready.
- Wait counter: width $clog2(MAX_WAIT+1); cleared on MEM entry; saturates and never wraps.
- rst_n asserted mid-instruction: immediate return to RESET with all outputs at reset values; any in-flight mem request is dropped.

## Configuration
- SEQ_PERF_CNT_EN defined:
  - Adds outputs cycle_cnt[31:0] (increments every cycle out of reset) and retired_cnt[31:0] (increments on done without trap).
  - Both wrap from 0xFFFFFFFF to 0 and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package seq_pkg:
  - state enum
  - instruction-class enum
  - opcode constants (0x33, 0x13, 0x03, 0x23, 0x63, 0x6F)
  - pc_sel encodings
  - alu_op encodings
- One natural sub-module: seq_class_decode, a combinational opcode-to-class decoder.
- FSM, wait counter and perf counters stay in the top module.

## Test plan
- Reset: hold rst_n=0 → all outputs 0. Release → cycle 1 pc_we=1, pc_sel=11; cycle 2 ir_we=1.
- R-type 0x33, int_req=0 → DECODE, EXEC alu_op=10 alu_src=0, WB reg_we=1 pc_we=1 pc_sel=00 done=1; 4 cycles total.
- LOAD 0x03, mem_ready high on the 4th MEM cycle → mem_rd high exactly 4 cycles; WB mem2reg=1 reg_we=1; 8 cycles total.
- BRANCH 0x63: zero=1 → EXEC pc_sel=01; zero=0 → pc_sel=00. Both 3 cycles, reg_we never asserted.
- int_req raised during a JAL's EXEC → WB reg_we=1, pc_sel=11 (not 10), int_ack=1 for exactly one cycle.
- Traps:
  - MAX_WAIT=4, STORE with mem_ready held 0 → 4 MEM cycles then trap=1, pc_sel=11.
  - Opcode 0x7F → trap in DECODE, no reg_we/mem_wr.
  - With SEQ_PERF_CNT_EN, retired_cnt unchanged in both cases.
